flat_vector_shuttle: RTL

- Sequential counterpart to the flattening wrappers used by the fuzz harness.
- Receives a narrow valid/ready chunk stream and assembles it into one complete `in_flat` stimulus vector.
- Holds that vector on the wrapper input, waits a settle window, then captures the wrapper's `out_flat`.
- Streams the captured result back out as chunks. It sits between the fuzz transport and any `*_wrapper` instance.

---
 rtl/flat_vector_shuttle_pkg.sv | 16 +
 rtl/flat_chunk_serializer.sv | 59 +++++
 rtl/flat_vector_shuttle.sv | 117 +++++++++++
 3 files changed

// File: rtl/flat_vector_shuttle_pkg.sv
// Shared types and helpers for the flat-vector shuttle and its chunk serializer.
package flat_shuttle_pkg;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SEND   = 2'd2
  } state_t;

  localparam int VEC_CNT_W = 16;

  function automatic int num_chunks(input int width, input int chunk_w);
    return (width + chunk_w - 1) / chunk_w;
  endfunction

endpackage

// File: rtl/flat_chunk_serializer.sv
// Parallel-load, MSB-first chunk serializer with valid/ready output.
// The top chunk is zero-padded when OUT_W is not a multiple of CHUNK_W.
module flat_chunk_serializer
  import flat_shuttle_pkg::*;
#(
  parameter int OUT_W   = 10,
  parameter int CHUNK_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               load,
  input  logic [OUT_W-1:0]   load_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [CHUNK_W-1:0] m_data,
  output logic               done
);

  localparam int NO    = num_chunks(OUT_W, CHUNK_W);
  localparam int PAD_W = NO * CHUNK_W;
  localparam int CNT_W = (NO > 1) ? $clog2(NO) : 1;

  logic [PAD_W-1:0] shadow;
  logic [CNT_W-1:0] cnt;
  logic             fire;
  logic             last;

  assign fire   = m_valid & m_ready & ~clear;
  assign last   = (cnt == CNT_W'(NO - 1));
  assign done   = fire & last;
  // Current chunk always sits at the top; the shift drains zeros in behind it.
  assign m_data = shadow[PAD_W-1 -: CHUNK_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      cnt     <= '0;
      m_valid <= 1'b0;
    end else if (clear) begin
      shadow  <= '0;
      cnt     <= '0;
      m_valid <= 1'b0;
    end else if (load) begin
      shadow  <= PAD_W'(load_data);
      cnt     <= '0;
      m_valid <= 1'b1;
    end else if (fire) begin
      shadow <= shadow << CHUNK_W;
      if (last) begin
        cnt     <= '0;
        m_valid <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/flat_vector_shuttle.sv
// Assembles chunked stimulus into in_flat, waits SETTLE cycles, captures
// out_flat and streams it back as chunks.
module flat_vector_shuttle
  import flat_shuttle_pkg::*;
#(
  parameter int IN_W    = 16,
  parameter int OUT_W   = 10,
  parameter int CHUNK_W = 8,
  parameter int SETTLE  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [CHUNK_W-1:0]   s_data,
  output logic [IN_W-1:0]      in_flat,
  input  logic [OUT_W-1:0]     out_flat,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [CHUNK_W-1:0]   m_data,
  output logic                 busy,
  output logic [VEC_CNT_W-1:0] vec_count
);

  localparam int NI     = num_chunks(IN_W, CHUNK_W);
  localparam int ICNT_W = (NI > 1) ? $clog2(NI) : 1;

  state_t            state, state_n;
  logic [IN_W-1:0]   shadow;
  logic [ICNT_W-1:0] in_cnt;
  logic [SETTLE:1]   vld_pipe;
  logic              s_fire;
  logic              in_last;
  logic              load_done;
  logic              capture;
  logic              ser_done;

  assign s_ready   = (state == ST_LOAD);
  assign busy      = (state != ST_LOAD);
  assign s_fire    = s_valid & s_ready & ~flush;
  assign in_last   = (in_cnt == ICNT_W'(NI - 1));
  assign load_done = s_fire & in_last;
  assign capture   = (state == ST_SETTLE) & vld_pipe[SETTLE] & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_LOAD;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_LOAD:   if (load_done) state_n = ST_SETTLE;
      ST_SETTLE: if (capture)   state_n = ST_SEND;
      ST_SEND:   if (ser_done)  state_n = ST_LOAD;
      default:                  state_n = ST_LOAD;
    endcase
    if (flush) state_n = ST_LOAD;
  end

  // Truncating cast keeps the low IN_W bits, so surplus high bits of the
  // first chunk fall off the top of the shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      in_cnt  <= '0;
      in_flat <= '0;
    end else if (flush) begin
      shadow <= '0;
      in_cnt <= '0;
    end else if (s_fire) begin
      if (in_last) begin
        in_flat <= IN_W'({shadow, s_data});
        shadow  <= '0;
        in_cnt  <= '0;
      end else begin
        shadow <= IN_W'({shadow, s_data});
        in_cnt <= in_cnt + 1'b1;
      end
    end
  end

  // A single token walks the settle window; it reaches the top bit in the
  // cycle before the capture edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else if (flush) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= load_done;
      for (int i = 2; i <= SETTLE; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        vec_count <= '0;
    else if (ser_done) vec_count <= vec_count + 1'b1;
  end

  flat_chunk_serializer #(
    .OUT_W   (OUT_W),
    .CHUNK_W (CHUNK_W)
  ) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush),
    .load      (capture),
    .load_data (out_flat),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .done      (ser_done)
  );

endmodule
